bridge_tx: RTL and testbench
============================

Name: bridge_tx

Overview:
- Terminal stage of the daisy-chained register bus.
- Consumes read responses leaving the last core in the chain (data/rw/valid) and serialises each one as an ASCII hex message into a byte stream for the UART transmitter.
- Byte stream uses a valid/ready handshake.
- The bus chain has no backpressure, so a one-entry pending buffer absorbs a response that arrives mid-message; any further response is dropped and flagged.

Parameters:
- PREFIX, 8'h4D ('M'): first byte of every response message.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous to clk, active-high.
- data_i  input  16  bus data from the last core in the chain.
- rw_i  input  1  bus rw from the chain; 0 = read response, 1 = write (no response sent).
- valid_i  input  1  bus valid from the chain; one-cycle pulse per transaction.
- data_o  output  8  byte to UART transmitter.
- valid_o  output  1  data_o holds a byte to send.
- ready_i  input  1  UART transmitter accepts data_o this cycle.
- busy_o  output  1  a message is in progress or pending.
- overflow_o  output  1  sticky; a read response was dropped.

Behaviour:
- Reset values: data_o=0, valid_o=0, busy_o=0, overflow_o=0. Active and pending buffers are empty; byte index is 0.
- Reset mid-message aborts the message. valid_o is 0 the cycle after rst. No partial resumption afterwards.
- Accept condition: a response is accepted when valid_i=1 and rw_i=0. valid_i with rw_i=1 is ignored entirely.
- Message format: 7 bytes, in order:
  - PREFIX
  - 4 hex digits, data_i[15:12] first down to [3:0]
  - 0x0D, then 0x0A
- Hex encoding: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase only).
- Transfer: a byte transfers on a cycle where valid_o && ready_i. While ready_i=0, data_o and valid_o are held stable.
- States: IDLE, SEND.
  - IDLE: an accepted response is latched into the active register; go to SEND with index 0. valid_o rises the next cycle with data_o=PREFIX (latency 1 cycle from valid_i).
  - SEND: index increments on each transfer. On transfer of index 6:
    - If pending is full: promote pending to active, index=0, stay in SEND. valid_o stays high; the next byte is PREFIX with no bubble.
    - Otherwise: go to IDLE; valid_o=0 the next cycle.
- Response arrival during SEND:
  - Pending empty: store in pending.
  - Pending full: drop the response and set overflow_o=1, held until rst.
- Simultaneous arrival with the index-6 transfer:
  - Pending empty: the new response becomes active directly (PREFIX next cycle).
  - Pending full: pending is promoted and the new response fills pending. No overflow.
- busy_o = (state==SEND) || pending full.
- Throughput: 7 cycles per message at ready_i=1 continuously.

Decomposition:
- bridge_pkg:
  - state enum (IDLE, SEND)
  - ASCII constants: CR=8'h0D, LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h41
  - MSG_LEN=7
- One sub-module: hex_to_ascii, combinational 4-bit nibble -> 8-bit uppercase ASCII byte. Used once via a nibble mux on the byte index.

Test Plan:
- Read response data_i=0x00A5, rw_i=0, ready_i=1 -> data_o sequence 4D 30 30 41 35 0D 0A on 7 consecutive cycles starting 1 cycle after valid_i; then valid_o=0 and busy_o=0.
- Write response data_i=0x0069, rw_i=1 -> valid_o stays 0 for 20 cycles; busy_o=0.
- Response 0xBEEF with ready_i toggling 1,0,0,1,... -> same 7 bytes 4D 42 45 45 46 0D 0A. data_o is unchanged while ready_i=0. No byte is lost or duplicated.
- Back-to-back overflow, all with ready_i=1:
  - 0x1234, then 0xABCD two cycles later -> 14 bytes contiguous: 4D 31 32 33 34 0D 0A 4D 41 42 43 44 0D 0A.
  - A third response 0x5555 on cycle 3 -> dropped; overflow_o=1 and stays 1.
- Reset mid-message: response 0x0012, assert rst after 3 bytes transferred -> valid_o=0, busy_o=0, overflow_o=0 next cycle. A subsequent response 0x0017 produces 4D 30 30 31 37 0D 0A from the beginning.
- Arrival coinciding with the index-6 transfer of 0x0001, pending empty, new response 0x0002 -> PREFIX of 0x0002 the very next cycle; overflow_o remains 0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the register-bus UART bridge transmitter.
package bridge_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    // Prefix, four hex digits, CR, LF.
    localparam int         MSG_LEN  = 7;
    localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_to_ascii
    import bridge_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + 8'(nibble);
        end else begin
            ascii = ASCII_A + 8'(nibble - 4'd10);
        end
    end

endmodule

// File: rtl/bridge_tx.sv
// Serialises read responses from the end of the register-bus chain into
// 7-byte ASCII hex messages on a valid/ready byte stream.  The chain cannot
// be stalled, so one response can wait in a pending slot; beyond that,
// responses are dropped and overflow_o latches.
module bridge_tx
    import bridge_pkg::*;
#(
    parameter logic [7:0] PREFIX = 8'h4D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        overflow_o
);

    state_t       state, nxt_state;
    logic [15:0]  active, nxt_active;
    logic [15:0]  pend, nxt_pend;
    logic         pend_full, nxt_pend_full;
    logic [2:0]   idx, nxt_idx;
    logic         nxt_ovf;
    logic [3:0]   nibble;
    logic [7:0]   hex_byte;
    logic [7:0]   nxt_byte;

    logic accept;
    logic xfer;

    assign accept = valid_i && !rw_i;
    assign xfer   = valid_o && ready_i;
    assign busy_o = (state == SEND) || pend_full;

    // Next-state: message sequencing, pending-slot promotion and overflow.
    always_comb begin
        nxt_state     = state;
        nxt_active    = active;
        nxt_pend      = pend;
        nxt_pend_full = pend_full;
        nxt_idx       = idx;
        nxt_ovf       = overflow_o;
        case (state)
            IDLE: begin
                if (accept) begin
                    nxt_active = data_i;
                    nxt_idx    = 3'd0;
                    nxt_state  = SEND;
                end
            end
            SEND: begin
                if (xfer && (idx == LAST_IDX)) begin
                    // Last byte leaves: chain straight into the next message
                    // so the stream has no bubble between messages.
                    nxt_idx = 3'd0;
                    if (pend_full) begin
                        nxt_active = pend;
                        if (accept) begin
                            nxt_pend = data_i;
                        end else begin
                            nxt_pend_full = 1'b0;
                        end
                    end else if (accept) begin
                        nxt_active = data_i;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        nxt_idx = idx + 3'd1;
                    end
                    if (accept) begin
                        if (!pend_full) begin
                            nxt_pend      = data_i;
                            nxt_pend_full = 1'b1;
                        end else begin
                            nxt_ovf = 1'b1;
                        end
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Select the digit of the upcoming byte; digit 1 is the most significant.
    always_comb begin
        case (nxt_idx)
            3'd1:    nibble = nxt_active[15:12];
            3'd2:    nibble = nxt_active[11:8];
            3'd3:    nibble = nxt_active[7:4];
            3'd4:    nibble = nxt_active[3:0];
            default: nibble = 4'd0;
        endcase
    end

    hex_to_ascii u_hex (
        .nibble (nibble),
        .ascii  (hex_byte)
    );

    // Byte that will be presented once the next state is registered.
    always_comb begin
        nxt_byte = 8'h00;
        if (nxt_state == SEND) begin
            case (nxt_idx)
                3'd0:                   nxt_byte = PREFIX;
                3'd1, 3'd2, 3'd3, 3'd4: nxt_byte = hex_byte;
                3'd5:                   nxt_byte = CR;
                3'd6:                   nxt_byte = LF;
                default:                nxt_byte = 8'h00;
            endcase
        end
    end

    // Control state and registered stream outputs; reset aborts any message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_full  <= 1'b0;
            idx        <= 3'd0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
            data_o     <= 8'h00;
        end else begin
            state      <= nxt_state;
            pend_full  <= nxt_pend_full;
            idx        <= nxt_idx;
            overflow_o <= nxt_ovf;
            valid_o    <= (nxt_state == SEND);
            data_o     <= nxt_byte;
        end
    end

    // Response payloads; qualified by state/pend_full so they need no reset.
    always_ff @(posedge clk) begin
        active <= nxt_active;
        pend   <= nxt_pend;
    end

endmodule

// File: tb/tb_bridge_tx.sv
// Scoreboard bench for bridge_tx: expected bytes are queued when a response
// is driven and compared as each byte is accepted on the output stream.
`timescale 1ns/1ps
module tb_bridge_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic       hold_armed = 1'b0;
    logic [7:0] held_byte  = 8'h00;

    always #5 clk = ~clk;

    bridge_tx #(.PREFIX(8'h4D)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9) return 8'h30 + 8'(n);
        return 8'h37 + 8'(n);
    endfunction

    // Queue the first cnt bytes of the message for value d.
    task automatic push_msg(input logic [15:0] d, input int cnt);
        logic [7:0] m [7];
        m[0] = 8'h4D;
        m[1] = hex_char(d[15:12]);
        m[2] = hex_char(d[11:8]);
        m[3] = hex_char(d[7:4]);
        m[4] = hex_char(d[3:0]);
        m[5] = 8'h0D;
        m[6] = 8'h0A;
        for (int i = 0; i < cnt; i++) exp_q.push_back(m[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bus pulse; cnt = number of bytes expected on the stream.
    task automatic send(input logic [15:0] d, input logic rw, input int cnt);
        data_i  = d;
        rw_i    = rw;
        valid_i = 1'b1;
        push_msg(d, cnt);
        tick();
        valid_i = 1'b0;
        rw_i    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !valid_o) break;
            tick();
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", valid_o, 1'b0);
        check("drain_busy", busy_o, 1'b0);
    endtask

    // Output monitor: scoreboard on every transfer, stability while stalled.
    always @(negedge clk) begin
        if (hold_armed) begin
            check("hold_valid", valid_o, 1'b1);
            check("hold_data", data_o, held_byte);
        end
        hold_armed = !rst && valid_o && !ready_i;
        held_byte  = data_o;
        if (!rst && valid_o && ready_i) begin
            check("sb_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("byte", data_o, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pat;
        pat     = 4'b1001;  // ready pattern 1,0,0,1 read from bit 3 down
        rst     = 1'b1;
        data_i  = 16'h0;
        rw_i    = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        check("rst_data", data_o, 8'h00);
        check("rst_valid", valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        rst = 1'b0;
        tick();

        // Single read response, latency one cycle.
        send(16'h00A5, 1'b0, 7);
        check("lat_valid", valid_o, 1'b1);
        check("lat_prefix", data_o, 8'h4D);
        check("busy_during", busy_o, 1'b1);
        drain();

        // Write transactions produce nothing.
        send(16'h0069, 1'b1, 0);
        for (int i = 0; i < 20; i++) begin
            check("write_valid", valid_o, 1'b0);
            check("write_busy", busy_o, 1'b0);
            tick();
        end

        // Backpressure with ready toggling.
        send(16'hBEEF, 1'b0, 7);
        for (int i = 0; i < 40; i++) begin
            ready_i = pat[3 - (i % 4)];
            tick();
        end
        ready_i = 1'b1;
        drain();

        // Back-to-back: second is buffered, third is dropped.
        send(16'h1234, 1'b0, 7);
        tick();
        send(16'hABCD, 1'b0, 7);
        send(16'h5555, 1'b0, 0);
        check("ovf_set", overflow_o, 1'b1);
        for (int i = 0; i < 11; i++) begin
            check("contig_valid", valid_o, 1'b1);
            tick();
        end
        check("contig_end", valid_o, 1'b0);
        check("ovf_sticky", overflow_o, 1'b1);
        drain();
        check("ovf_sticky2", overflow_o, 1'b1);

        // Reset after three bytes have transferred.
        send(16'h0012, 1'b0, 3);
        tick();
        tick();
        tick();
        ready_i = 1'b0;
        rst     = 1'b1;
        tick();
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_ovf", overflow_o, 1'b0);
        rst     = 1'b0;
        ready_i = 1'b1;
        tick();
        check("mid_rst_queue", exp_q.size(), 0);
        send(16'h0017, 1'b0, 7);
        drain();

        // New response on the same edge as the last byte of the previous one.
        send(16'h0001, 1'b0, 7);
        for (int i = 0; i < 6; i++) tick();
        check("coin_last_byte", data_o, 8'h0A);
        send(16'h0002, 1'b0, 7);
        check("coin_valid", valid_o, 1'b1);
        check("coin_prefix", data_o, 8'h4D);
        drain();
        check("coin_ovf", overflow_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
